sdr_cmd_decoder: RTL

// - Passive receive-side decoder for the SDRAM command bus (cke/cs_n/ras_n/cas_n/we_n/ba/addr) that the SDRAM controller core drives.
// - Decodes each sampled command and tracks per-bank open/row state, tRCD spacing, the refresh interval and the CAS-latency read-data window.
// - Reports protocol violations as sticky flags for the testbench scoreboard and coverage.
// - Sits on the SDRAM side, between the controller core and the SDRAM model. It drives nothing onto the bus.

---
 rtl/sdr_cmd_decoder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/sdr_cmd_decoder.sv
// Passive SDRAM command-bus decoder: registers the decoded command, tracks per-bank
// open state and tRCD spacing, the refresh interval and the CAS-latency read window,
// and raises sticky protocol-violation flags. Drives nothing onto the bus.
module sdr_cmd_decoder #(
  parameter int unsigned P_BANKS = 4,
  parameter int unsigned P_AW    = 13,
  parameter int unsigned P_TRCD  = 3,
  parameter int unsigned P_BL    = 1
) (
  input  logic               sdram_clk,
  input  logic               reset_n,
  input  logic               sdr_cke,
  input  logic               sdr_cs_n,
  input  logic               sdr_ras_n,
  input  logic               sdr_cas_n,
  input  logic               sdr_we_n,
  input  logic [1:0]         sdr_ba,
  input  logic [P_AW-1:0]    sdr_addr,
  input  logic [2:0]         cfg_sdr_cas,
  input  logic [11:0]        cfg_sdr_rfsh,
  input  logic               err_clr,
  output logic [3:0]         cmd_o,
  output logic [1:0]         cmd_bank_o,
  output logic [P_BANKS-1:0] bank_open_o,
  output logic               rd_data_valid,
  output logic [15:0]        rfsh_cnt_o,
  output logic [4:0]         err_o
);

  localparam int unsigned     LP_TW        = (P_TRCD > 2) ? $clog2(P_TRCD) : 1;
  localparam logic [LP_TW-1:0] LP_TRCD_LOAD = LP_TW'(P_TRCD - 1);
  // Burst window pattern; windows reaching past the 8-bit register are clipped.
  localparam logic [7:0]      LP_BL_MASK   = 8'((16'd1 << P_BL) - 16'd1);

  typedef enum logic [3:0] {
    CmdDesel = 4'd0,
    CmdNop   = 4'd1,
    CmdAct   = 4'd2,
    CmdRead  = 4'd3,
    CmdWrite = 4'd4,
    CmdPre   = 4'd5,
    CmdRef   = 4'd6,
    CmdMrs   = 4'd7,
    CmdBst   = 4'd8
  } cmd_e;

  cmd_e               w_cmd;
  cmd_e               r_cmd;
  logic [1:0]         r_bank;
  logic [P_BANKS-1:0] r_open;
  logic [P_BANKS-1:0] w_open_nxt;
  logic [LP_TW-1:0]   r_trcd     [P_BANKS];
  logic [LP_TW-1:0]   w_trcd_nxt [P_BANKS];
  logic [4:0]         r_err;
  logic [4:0]         w_err_set;
  logic [4:0]         w_err_nxt;
  logic [11:0]        r_rint;
  logic [11:0]        w_rint_nxt;
  logic [15:0]        r_rcnt;
  logic [15:0]        w_rcnt_nxt;
  logic [7:0]         r_sh;
  logic [7:0]         w_sh_nxt;
  logic [2:0]         w_cas_eff;
  logic               w_a10;

  assign w_a10         = sdr_addr[10];
  assign cmd_o         = r_cmd;
  assign cmd_bank_o    = r_bank;
  assign bank_open_o   = r_open;
  assign rd_data_valid = r_sh[0];
  assign rfsh_cnt_o    = r_rcnt;
  assign err_o         = r_err;

  // Decode the sampled bus pins into a command code; cke low masks everything to NOP.
  always_comb begin
    w_cmd = CmdNop;
    if (!sdr_cke) begin
      w_cmd = CmdNop;
    end else if (sdr_cs_n) begin
      w_cmd = CmdDesel;
    end else begin
      case ({sdr_ras_n, sdr_cas_n, sdr_we_n})
        3'b111:  w_cmd = CmdNop;
        3'b011:  w_cmd = CmdAct;
        3'b101:  w_cmd = CmdRead;
        3'b100:  w_cmd = CmdWrite;
        3'b010:  w_cmd = CmdPre;
        3'b001:  w_cmd = CmdRef;
        3'b000:  w_cmd = CmdMrs;
        default: w_cmd = CmdBst;
      endcase
    end
  end

  // Next bank state, tRCD counters and the protocol violations raised this cycle.
  always_comb begin
    w_open_nxt = r_open;
    w_err_set  = '0;
    for (int b = 0; b < P_BANKS; b++) begin
      w_trcd_nxt[b] = (r_trcd[b] != '0) ? r_trcd[b] - LP_TW'(1) : '0;
    end
    case (w_cmd)
      CmdAct: begin
        w_err_set[0]       = r_open[sdr_ba];
        w_open_nxt[sdr_ba] = 1'b1;
        w_trcd_nxt[sdr_ba] = LP_TRCD_LOAD;
      end
      CmdRead, CmdWrite: begin
        w_err_set[1] = ~r_open[sdr_ba];
        w_err_set[2] = (r_trcd[sdr_ba] != '0);
        if (w_a10) begin
          w_open_nxt[sdr_ba] = 1'b0;
        end
      end
      CmdPre: begin
        if (w_a10) begin
          w_open_nxt = '0;
        end else begin
          w_open_nxt[sdr_ba] = 1'b0;
        end
      end
      CmdRef: begin
        w_err_set[3] = |r_open;
      end
      default: ;
    endcase
    // A REF landing exactly on the limit still counts as on time.
    if ((cfg_sdr_rfsh != 12'd0) && (r_rint == cfg_sdr_rfsh) && (w_cmd != CmdRef)) begin
      w_err_set[4] = 1'b1;
    end
    // A violation in the clearing cycle survives the clear.
    w_err_nxt = (err_clr ? 5'd0 : r_err) | w_err_set;
  end

  // Next refresh interval / REF count and read-window shift register.
  always_comb begin
    w_cas_eff  = (cfg_sdr_cas == 3'd0) ? 3'd1 : cfg_sdr_cas;
    w_rint_nxt = (r_rint == 12'hFFF) ? r_rint : r_rint + 12'd1;
    w_rcnt_nxt = r_rcnt;
    if (w_cmd == CmdRef) begin
      w_rint_nxt = '0;
      w_rcnt_nxt = r_rcnt + 16'd1;
    end
    // Bit 0 is the current cycle; bit n becomes valid n edges from now.
    w_sh_nxt = {1'b0, r_sh[7:1]};
    if (w_cmd == CmdRead) begin
      w_sh_nxt = w_sh_nxt | (LP_BL_MASK << w_cas_eff);
    end else if (w_cmd == CmdBst) begin
      w_sh_nxt = '0;
    end
  end

  // Register the decoded command and its bank.
  always_ff @(posedge sdram_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd  <= CmdNop;
      r_bank <= '0;
    end else begin
      r_cmd  <= w_cmd;
      r_bank <= sdr_ba;
    end
  end

  // Bank open state, tRCD counters and sticky error flags.
  always_ff @(posedge sdram_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_open <= '0;
      r_err  <= '0;
      for (int b = 0; b < P_BANKS; b++) begin
        r_trcd[b] <= '0;
      end
    end else begin
      r_open <= w_open_nxt;
      r_err  <= w_err_nxt;
      for (int b = 0; b < P_BANKS; b++) begin
        r_trcd[b] <= w_trcd_nxt[b];
      end
    end
  end

  // Refresh interval, REF count and read-window state.
  always_ff @(posedge sdram_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rint <= '0;
      r_rcnt <= '0;
      r_sh   <= '0;
    end else begin
      r_rint <= w_rint_nxt;
      r_rcnt <= w_rcnt_nxt;
      r_sh   <= w_sh_nxt;
    end
  end

endmodule
